// File: rtl/channel_rom_arbiter_pkg.sv
// Shared defaults and width helpers for the channel ROM arbiter and its
// round-robin picker; also imported by the channel controller tops.
package channel_rom_arbiter_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int ROM_LATENCY_DEF = 1;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/channel_rom_arbiter_picker.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest
// set bit, then map that offset back to an absolute channel index.
module rr_priority_picker
  import channel_rom_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int PTR_W  = ptr_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] winner,
  output logic [PTR_W-1:0]  winner_idx,
  output logic              any
);

  localparam logic [PTR_W:0] CH_CNT = (PTR_W+1)'(NUM_CH);

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rotated;
  logic [PTR_W-1:0]    offset;
  logic [PTR_W:0]      sum;

  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[NUM_CH-1:0];
    offset  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rotated[i]) offset = PTR_W'(i);
    end
    // Explicit wrap so non-power-of-2 channel counts never rely on overflow.
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= CH_CNT) sum = sum - CH_CNT;
    winner_idx = sum[PTR_W-1:0];
    any        = |req;
    winner     = any ? (NUM_CH'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/channel_rom_arbiter.sv
// Round-robin sharing of one synchronous ROM between NUM_CH requesters: one
// read issued per clock, a one-hot tag follows each read to route the data back.
module channel_rom_arbiter
  import channel_rom_arbiter_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_CH-1:0]            o_grant,
  output logic [NUM_CH-1:0]            o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_busy,
  output logic [ADDR_WIDTH-1:0]        o_rom_addr,
  input  logic [DATA_WIDTH-1:0]        i_rom_data
);

  localparam int              PTR_W   = ptr_width(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  logic [PTR_W-1:0]      ptr_p0;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     win_oh;
  logic [PTR_W-1:0]      win_idx;
  logic                  win_any;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [NUM_CH-1:0]     vld_p [ROM_LATENCY];

  // A requester still holding req in its own grant cycle must not win twice.
  assign elig = i_req & ~o_grant;

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req        (elig),
    .ptr        (ptr_p0),
    .winner     (win_oh),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  assign win_addr = i_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];

  // ---- issue stage: grant pulse, ROM address, round-robin pointer ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant    <= '0;
      o_rom_addr <= '0;
      ptr_p0     <= '0;
    end else begin
      o_grant <= win_oh;
      if (win_any) begin
        o_rom_addr <= win_addr;
        ptr_p0     <= (win_idx == LAST_CH) ? '0 : win_idx + PTR_W'(1);
      end
    end
  end

  // ---- tag pipeline: tracks the ROM's read latency ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < ROM_LATENCY; k++) vld_p[k] <= '0;
    end else begin
      vld_p[0] <= o_grant;
      for (int k = 1; k < ROM_LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // ---- output stage: registered data, held between valid pulses ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= vld_p[ROM_LATENCY-1];
      if (|vld_p[ROM_LATENCY-1]) o_data <= i_rom_data;
    end
  end

  always_comb begin
    o_busy = |o_grant;
    for (int k = 0; k < ROM_LATENCY; k++) o_busy = o_busy | (|vld_p[k]);
  end

endmodule

// File: tb/tb_channel_rom_arbiter.sv
// Bench for channel_rom_arbiter: ROM_LATENCY=1 and =3 instances share stimulus
// and are checked each cycle against a transaction-level arbitration model.
module tb_channel_rom_arbiter;

  localparam int NUM_CH = 4;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int MAXC   = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NUM_CH-1:0]      req;
  logic [AW-1:0]          a [NUM_CH];
  logic [NUM_CH*AW-1:0]   addr_flat;

  logic [NUM_CH-1:0] g1, v1, g3, v3;
  logic [DW-1:0]     d1, d3, rd1, rd3;
  logic              b1, b3;
  logic [AW-1:0]     ra1, ra3;

  always_comb begin
    addr_flat = '0;
    for (int k = 0; k < NUM_CH; k++) addr_flat[k*AW +: AW] = a[k];
  end

  channel_rom_arbiter #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr_flat),
    .o_grant(g1), .o_valid(v1), .o_data(d1), .o_busy(b1),
    .o_rom_addr(ra1), .i_rom_data(rd1));

  channel_rom_arbiter #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr_flat),
    .o_grant(g3), .o_valid(v3), .o_data(d3), .o_busy(b3),
    .o_rom_addr(ra3), .i_rom_data(rd3));

  // Synchronous ROMs with 1 and 3 clocks of read latency.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rom1_q;
  logic [DW-1:0] rom3_q [3];
  always_ff @(posedge clk) begin
    rom1_q    <= mem[ra1];
    rom3_q[0] <= mem[ra3];
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rd1 = rom1_q;
  assign rd3 = rom3_q[2];

  // Reference model state.
  int                cyc;
  bit [NUM_CH-1:0]   m_grant;
  int                m_ptr;
  bit [AW-1:0]       m_raddr;
  bit [DW-1:0]       m_d1, m_d3;
  bit [NUM_CH-1:0]   ghist [MAXC];
  bit [NUM_CH-1:0]   ev1 [MAXC];
  bit [NUM_CH-1:0]   ev3 [MAXC];
  bit [DW-1:0]       ed1 [MAXC];
  bit [DW-1:0]       ed3 [MAXC];

  int checks = 0;
  int errors = 0;
  int wait_cnt [NUM_CH];
  int max_wait;
  bit track_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Busy while any grant issued in the last lat+1 cycles has not yet produced its valid.
  function automatic bit busy_exp(input int lat);
    bit b = 1'b0;
    for (int k = 0; k <= lat; k++) if (cyc - k >= 0) b |= (ghist[cyc-k] != '0);
    return b;
  endfunction

  task automatic compare_all();
    chk("grant_l1",   32'(g1),  32'(m_grant));
    chk("grant_l3",   32'(g3),  32'(m_grant));
    chk("valid_l1",   32'(v1),  32'(ev1[cyc]));
    chk("valid_l3",   32'(v3),  32'(ev3[cyc]));
    chk("data_l1",    32'(d1),  32'(m_d1));
    chk("data_l3",    32'(d3),  32'(m_d3));
    chk("busy_l1",    32'(b1),  32'(busy_exp(1)));
    chk("busy_l3",    32'(b3),  32'(busy_exp(3)));
    chk("romaddr_l1", 32'(ra1), 32'(m_raddr));
    chk("romaddr_l3", 32'(ra3), 32'(m_raddr));
  endtask

  task automatic step();
    bit [NUM_CH-1:0] e;
    bit found;
    int w;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      e = req & ~m_grant;
      m_grant = '0;
      found = 1'b0;
      w = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && e[(m_ptr + i) % NUM_CH]) begin
          found = 1'b1;
          w = (m_ptr + i) % NUM_CH;
        end
      end
      if (found) begin
        m_grant[w] = 1'b1;
        m_raddr    = a[w];
        m_ptr      = (w + 1) % NUM_CH;
        ev1[cyc+2] = m_grant;
        ed1[cyc+2] = mem[a[w]];
        ev3[cyc+4] = m_grant;
        ed3[cyc+4] = mem[a[w]];
      end
    end else begin
      m_grant = '0;
    end
    ghist[cyc] = m_grant;
    #1;
    if (ev1[cyc] != '0) m_d1 = ed1[cyc];
    if (ev3[cyc] != '0) m_d3 = ed3[cyc];
    for (int k = 0; k < NUM_CH; k++) begin
      if (track_wait && rst_n && req[k] && !g1[k]) wait_cnt[k]++;
      else wait_cnt[k] = 0;
      if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
    end
    compare_all();
  endtask

  task automatic do_reset(input int edges);
    rst_n   = 1'b0;
    m_grant = '0;
    m_ptr   = 0;
    m_raddr = '0;
    m_d1    = '0;
    m_d3    = '0;
    for (int i = cyc - 4; i <= cyc; i++) if (i >= 0) ghist[i] = '0;
    for (int i = cyc; i <= cyc + 8; i++) begin
      ev1[i] = '0;
      ev3[i] = '0;
    end
    #1;
    compare_all();
    repeat (edges) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [NUM_CH-1:0] oh;
    cyc        = 0;
    m_ptr      = 0;
    max_wait   = 0;
    track_wait = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h15] = 16'hA5A5;
    for (int k = 0; k < NUM_CH; k++) begin
      a[k]        = AW'(8'h10 + k);
      wait_cnt[k] = 0;
    end

    // Reset with every channel requesting, then held round robin.
    req = 4'hF;
    do_reset(3);
    step();
    chk("t1_first_grant", 32'(g1), 32'h1);
    chk("t1_rom_addr", 32'(ra1), 32'h10);
    for (int i = 1; i < 8; i++) begin
      step();
      oh = '0;
      oh[i % NUM_CH] = 1'b1;
      chk("t3_rr_order", 32'(g1), 32'(oh));
    end
    req = '0;
    repeat (6) step();

    // Single read from ch2.
    a[2] = 8'h15;
    req  = 4'b0100;
    step();
    chk("t2_grant", 32'(g1), 32'b0100);
    req = '0;
    repeat (2) step();
    chk("t2_valid_l1", 32'(v1), 32'b0100);
    chk("t2_data_l1", 32'(d1), 32'hA5A5);
    repeat (2) step();
    chk("t2_valid_l3", 32'(v3), 32'b0100);
    chk("t2_data_l3", 32'(d3), 32'hA5A5);
    step();
    chk("t2_idle_l1", 32'(b1), 32'h0);
    chk("t2_idle_l3", 32'(b3), 32'h0);

    // Pointer now at 3: wrap to ch0, skip ch1, then ch2.
    a[0] = 8'h20;
    a[2] = 8'h22;
    req  = 4'b0101;
    step();
    chk("t4_wrap_ch0", 32'(g1), 32'b0001);
    req[0] = 1'b0;
    step();
    chk("t4_skip_ch2", 32'(g1), 32'b0100);
    req = '0;
    repeat (6) step();

    // One requester held high: granted every other cycle.
    a[1] = 8'h31;
    req  = 4'b0010;
    cnt  = 0;
    repeat (10) begin
      step();
      if (g1 == 4'b0010) cnt++;
    end
    req = '0;
    chk("t5_grant_count", 32'(cnt), 32'd5);
    repeat (6) step();

    // Reset while a read is in flight; the first case lands ptr at 0, the second at 1.
    for (int t = 0; t < 2; t++) begin
      req = (t == 0) ? 4'b1000 : 4'b0001;
      step();
      chk("t6_grant", 32'(g1), (t == 0) ? 32'b1000 : 32'b0001);
      req = '0;
      step();
      do_reset(1);
      repeat (5) begin
        step();
        chk("t6_no_valid_l1", 32'(v1), 32'h0);
        chk("t6_no_valid_l3", 32'(v3), 32'h0);
      end
      req = (t == 0) ? 4'b0101 : 4'b0011;
      step();
      chk("t6_after_reset_ch0", 32'(g1), 32'b0001);
      req = '0;
      repeat (6) step();
    end

    // Random requesters obeying the handshake.
    track_wait = 1'b1;
    repeat (150) begin
      step();
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_grant[k]) begin
          if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
          else a[k] = AW'($urandom);
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k] = 1'b1;
          a[k]   = AW'($urandom);
        end
      end
    end
    track_wait = 1'b0;
    req = '0;
    repeat (8) step();
    chk("t4_no_starvation", 32'(max_wait <= NUM_CH), 32'h1);
    chk("drain_idle_l3", 32'(b3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
